// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter for
// the single write port of the shared fifo.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 8,
  parameter  int BURST_MAX = 4,
  localparam int OW = (NUM_REQ > 1) ?
                      $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(BURST_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  input  logic                      fifo_full,
  output logic                      fifo_write,
  output logic [DATA_W-1:0]         fifo_data,
  output logic [OW-1:0]             owner,
  output logic                      busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] owner_d;
  logic [OW-1:0] last_q;
  logic [OW-1:0] last_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic          found;
  logic [OW-1:0] pick;
  logic [OW-1:0] cand;
  logic          own_req;
  logic          own_st;
  logic          wr;
  logic          last_beat;

  assign own_st    = (state_q == OWN);
  assign own_req   = req[owner_q];
  assign wr        = own_st & own_req & ~fifo_full;
  assign last_beat = (cnt_q == CW'(BURST_MAX - 1));

  // Round-robin scan: first request after last_owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((int'(last_q) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state: grant, count beats, release.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (wr) begin
          cnt_d = cnt_q + CW'(1);
          if (last_beat) begin
            last_d  = owner_q;
            state_d = IDLE;
          end
        end else if (!own_req) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant and write-port mux, zero outside OWN.
  always_comb begin
    gnt       = '0;
    fifo_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (own_st && owner_q == OW'(i)) begin
        gnt[i]    = 1'b1;
        fifo_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign fifo_write = wr;
  assign owner      = owner_q;
  assign busy       = own_st;

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
